// File: rtl/wts_timer_pkg.sv
// Shared types and constants for the WTS timer trigger block.
package wts_timer_pkg;

    localparam int unsigned WTS_TIMER_ADDR_W       = 2;
    localparam int unsigned WTS_TIMER_DIV_DEF      = 256;
    localparam int unsigned WTS_TIMER_PERIOD_W_DEF = 12;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_e;

endpackage

// File: rtl/wts_timer_trigger_if.sv
// Host-side control and trigger-side status signals of the two timer channels.
interface wts_timer_trigger_if #(
    parameter int unsigned PERIOD_W = 12
);
    import wts_timer_pkg::*;

    logic [PERIOD_W-1:0]         timer1_period;
    logic                        timer1_repeat;
    logic                        timer1_start;
    logic                        timer1_stop;
    logic                        timer1_trigger;
    logic [WTS_TIMER_ADDR_W-1:0] timer1_address;
    logic                        timer1_busy;

    logic [PERIOD_W-1:0]         timer2_period;
    logic                        timer2_repeat;
    logic                        timer2_start;
    logic                        timer2_stop;
    logic                        timer2_trigger;
    logic [WTS_TIMER_ADDR_W-1:0] timer2_address;
    logic                        timer2_busy;
    logic                        timer2_cascade;

    modport master (
        output timer1_period, timer1_repeat, timer1_start, timer1_stop,
        output timer2_period, timer2_repeat, timer2_start, timer2_stop, timer2_cascade,
        input  timer1_trigger, timer1_address, timer1_busy,
        input  timer2_trigger, timer2_address, timer2_busy
    );

    modport slave (
        input  timer1_period, timer1_repeat, timer1_start, timer1_stop,
        input  timer2_period, timer2_repeat, timer2_start, timer2_stop, timer2_cascade,
        output timer1_trigger, timer1_address, timer1_busy,
        output timer2_trigger, timer2_address, timer2_busy
    );

endinterface

// File: rtl/wts_timer_trigger_ch.sv
// One timer channel: IDLE/RUN FSM, period down-counter, rolling address phase, registered outputs.
module wts_timer_trigger_ch
    import wts_timer_pkg::*;
#(
    parameter int unsigned PERIOD_W = WTS_TIMER_PERIOD_W_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cnt_en,
    input  logic [PERIOD_W-1:0]         period,
    input  logic                        reload,
    input  logic                        start,
    input  logic                        stop,
    output logic                        trigger,
    output logic [WTS_TIMER_ADDR_W-1:0] address,
    output logic                        busy
);

    ch_state_e                   state_q, state_d;
    logic [PERIOD_W-1:0]         cnt_q, cnt_d;
    logic [WTS_TIMER_ADDR_W-1:0] phase_q, phase_d;
    logic [WTS_TIMER_ADDR_W-1:0] address_q, address_d;
    logic                        trigger_q, trigger_d;
    logic                        busy_q, busy_d;

    // Priority: stop over start over counting; a stop also suppresses a coincident expiry.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        phase_d   = phase_q;
        address_d = address_q;
        trigger_d = 1'b0;

        if (stop) begin
            state_d = ST_IDLE;
        end else if (start) begin
            state_d = ST_RUN;
            cnt_d   = period;
        end else if (state_q == ST_RUN && cnt_en) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - PERIOD_W'(1);
            end else begin
                trigger_d = 1'b1;
                address_d = phase_q;
                phase_d   = phase_q + WTS_TIMER_ADDR_W'(1);
                if (reload) begin
                    cnt_d = period;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        end

        busy_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            phase_q   <= '0;
            address_q <= '0;
            trigger_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            address_q <= address_d;
            trigger_q <= trigger_d;
            busy_q    <= busy_d;
        end
    end

    assign trigger = trigger_q;
    assign address = address_q;
    assign busy    = busy_q;

endmodule

// File: rtl/wts_timer_trigger.sv
// Two-channel interval trigger generator with a shared base-tick prescaler.
// Optional macro WTS_TIMER_TRIGGER_CASCADE_EN lets channel 2 count channel-1 triggers.
module wts_timer_trigger
    import wts_timer_pkg::*;
#(
    parameter int unsigned PERIOD_W = WTS_TIMER_PERIOD_W_DEF,
    parameter int unsigned DIV      = WTS_TIMER_DIV_DEF
) (
    input logic                clk,
    input logic                reset,
    wts_timer_trigger_if.slave bus
);

    localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PRE_W-1:0]            pre_q, pre_d;
    logic                        tick_q, tick_d;
    logic                        pre_wrap_c;
    logic                        ch2_en_c;
    logic                        ch1_trigger;
    logic [WTS_TIMER_ADDR_W-1:0] ch1_address;
    logic                        ch1_busy;
    logic                        ch2_trigger;
    logic [WTS_TIMER_ADDR_W-1:0] ch2_address;
    logic                        ch2_busy;

    // Free-running prescaler; base tick is registered so it lands one cycle after the wrap count.
    always_comb begin
        pre_wrap_c = (pre_q == PRE_W'(DIV - 1));
        pre_d      = pre_wrap_c ? '0 : pre_q + PRE_W'(1);
        tick_d     = pre_wrap_c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= tick_d;
        end
    end

`ifdef WTS_TIMER_TRIGGER_CASCADE_EN
    assign ch2_en_c = bus.timer2_cascade ? ch1_trigger : tick_q;
`else
    logic unused_cascade;
    assign unused_cascade = bus.timer2_cascade;
    assign ch2_en_c       = tick_q;
`endif

    wts_timer_trigger_ch #(.PERIOD_W(PERIOD_W)) u_ch1 (
        .clk     (clk),
        .reset   (reset),
        .cnt_en  (tick_q),
        .period  (bus.timer1_period),
        .reload  (bus.timer1_repeat),
        .start   (bus.timer1_start),
        .stop    (bus.timer1_stop),
        .trigger (ch1_trigger),
        .address (ch1_address),
        .busy    (ch1_busy)
    );

    wts_timer_trigger_ch #(.PERIOD_W(PERIOD_W)) u_ch2 (
        .clk     (clk),
        .reset   (reset),
        .cnt_en  (ch2_en_c),
        .period  (bus.timer2_period),
        .reload  (bus.timer2_repeat),
        .start   (bus.timer2_start),
        .stop    (bus.timer2_stop),
        .trigger (ch2_trigger),
        .address (ch2_address),
        .busy    (ch2_busy)
    );

    assign bus.timer1_trigger = ch1_trigger;
    assign bus.timer1_address = ch1_address;
    assign bus.timer1_busy    = ch1_busy;
    assign bus.timer2_trigger = ch2_trigger;
    assign bus.timer2_address = ch2_address;
    assign bus.timer2_busy    = ch2_busy;

endmodule

// File: tb/tb_wts_timer_trigger.sv
// Self-checking bench for wts_timer_trigger: per-cycle reference model plus directed literal checks.
module tb_wts_timer_trigger;
    import wts_timer_pkg::*;

    localparam int unsigned DIV = 4;
    localparam int unsigned PW  = 12;
`ifdef WTS_TIMER_TRIGGER_CASCADE_EN
    localparam int CASC_GAP = 24;
`else
    localparam int CASC_GAP = 12;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    wts_timer_trigger_if #(.PERIOD_W(PW)) bus ();

    wts_timer_trigger #(.PERIOD_W(PW), .DIV(DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec  = 0;
    int n_err  = 0;
    int tcyc   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: channel expressed as running flag, ticks left, and next tag.
    typedef struct {
        bit run;
        int rem;
        int phase;
        bit trig;
        int addr;
    } ch_m_t;

    ch_m_t m1, m2;
    int    mcyc = 0;

    function automatic void ch_step(inout ch_m_t m, input bit en, input int period,
                                    input bit rpt, input bit start, input bit stop);
        m.trig = 1'b0;
        if (stop) begin
            m.run = 1'b0;
        end else if (start) begin
            m.run = 1'b1;
            m.rem = period;
        end else if (m.run && en) begin
            if (m.rem > 0) begin
                m.rem = m.rem - 1;
            end else begin
                m.trig  = 1'b1;
                m.addr  = m.phase;
                m.phase = (m.phase + 1) % 4;
                if (rpt) m.rem = period;
                else     m.run = 1'b0;
            end
        end
    endfunction

    always @(posedge clk) begin
        tcyc++;
        if (reset) begin
            m1   = '{1'b0, 0, 0, 1'b0, 0};
            m2   = '{1'b0, 0, 0, 1'b0, 0};
            mcyc = 0;
        end else begin
            bit tick;
            bit en2;
            tick = (mcyc > 0) && (mcyc % DIV == 0);
`ifdef WTS_TIMER_TRIGGER_CASCADE_EN
            en2 = bus.timer2_cascade ? m1.trig : tick;
`else
            en2 = tick;
`endif
            ch_step(m1, tick, int'(bus.timer1_period), bus.timer1_repeat,
                    bus.timer1_start, bus.timer1_stop);
            ch_step(m2, en2, int'(bus.timer2_period), bus.timer2_repeat,
                    bus.timer2_start, bus.timer2_stop);
            mcyc++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("t1_trigger", int'(bus.timer1_trigger), int'(m1.trig));
            check("t1_address", int'(bus.timer1_address), m1.addr);
            check("t1_busy",    int'(bus.timer1_busy),    int'(m1.run));
            check("t2_trigger", int'(bus.timer2_trigger), int'(m2.trig));
            check("t2_address", int'(bus.timer2_address), m2.addr);
            check("t2_busy",    int'(bus.timer2_busy),    int'(m2.run));
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_trig(input int ch, input int budget, output int t);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            cycle();
            if ((ch == 1 && bus.timer1_trigger) || (ch == 2 && bus.timer2_trigger)) begin
                t = tcyc;
                return;
            end
        end
        n_vec++;
        n_err++;
        $display("FAIL wait_trig ch%0d: no trigger within %0d cycles", ch, budget);
    endtask

    initial begin
        int t[5];
        int a[5];
        int exp_a[5];
        int t0, t1, t2, cnt;

        exp_a = '{0, 1, 2, 3, 0};
        bus.timer1_period  = '0;
        bus.timer1_repeat  = 1'b0;
        bus.timer1_start   = 1'b0;
        bus.timer1_stop    = 1'b0;
        bus.timer2_period  = '0;
        bus.timer2_repeat  = 1'b0;
        bus.timer2_start   = 1'b0;
        bus.timer2_stop    = 1'b0;
        bus.timer2_cascade = 1'b0;

        // Reset for five cycles
        cycle();
        chk_en = 1'b1;
        repeat (4) cycle();
        check("rst_t1_trigger", int'(bus.timer1_trigger), 0);
        check("rst_t1_busy",    int'(bus.timer1_busy),    0);
        check("rst_t2_address", int'(bus.timer2_address), 0);
        reset = 1'b0;

        // Auto-reload, period 2: every 12 clocks, tags 0,1,2,3,0
        bus.timer1_period = PW'(2);
        bus.timer1_repeat = 1'b1;
        bus.timer1_start  = 1'b1;
        cycle();
        bus.timer1_start  = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wait_trig(1, 40, t[k]);
            a[k] = int'(bus.timer1_address);
            check("t1_busy_on_trig", int'(bus.timer1_busy), 1);
            check("t1_addr_seq", a[k], exp_a[k]);
            if (k > 0) check("t1_gap_p2", t[k] - t[k-1], 12);
        end
        bus.timer1_stop = 1'b1;
        cycle();
        bus.timer1_stop = 1'b0;

        // One-shot on ch2 with period 0
        bus.timer2_period = PW'(0);
        bus.timer2_repeat = 1'b0;
        bus.timer2_start  = 1'b1;
        cycle();
        bus.timer2_start  = 1'b0;
        wait_trig(2, 20, t0);
        check("t2_oneshot_addr", int'(bus.timer2_address), 0);
        check("t2_oneshot_busy", int'(bus.timer2_busy), 0);
        cnt = 0;
        repeat (100) begin
            cycle();
            if (bus.timer2_trigger) cnt++;
        end
        check("t2_oneshot_extra", cnt, 0);

        // Stop coinciding with expiry suppresses the trigger and the tag advance
        bus.timer1_period = PW'(0);
        bus.timer1_start  = 1'b1;
        cycle();
        bus.timer1_start  = 1'b0;
        wait_trig(1, 20, t0);
        check("t1_resume_addr", int'(bus.timer1_address), 1);
        repeat (3) cycle();
        bus.timer1_stop = 1'b1;
        cycle();
        bus.timer1_stop = 1'b0;
        check("t1_stop_exp_trig", int'(bus.timer1_trigger), 0);
        check("t1_stop_exp_busy", int'(bus.timer1_busy), 0);
        bus.timer1_start = 1'b1;
        cycle();
        bus.timer1_start = 1'b0;
        wait_trig(1, 20, t0);
        check("t1_unadvanced_addr", int'(bus.timer1_address), 2);
        bus.timer1_stop = 1'b1;
        cycle();
        bus.timer1_stop = 1'b0;

        // Start and stop together: stop wins
        bus.timer2_start = 1'b1;
        bus.timer2_stop  = 1'b1;
        cycle();
        bus.timer2_start = 1'b0;
        bus.timer2_stop  = 1'b0;
        check("t2_start_stop_busy", int'(bus.timer2_busy), 0);

        // Period change mid-count applies only after the next reload
        bus.timer1_period = PW'(5);
        bus.timer1_repeat = 1'b1;
        bus.timer1_start  = 1'b1;
        cycle();
        bus.timer1_start  = 1'b0;
        wait_trig(1, 60, t0);
        bus.timer1_period = PW'(1);
        wait_trig(1, 60, t1);
        wait_trig(1, 60, t2);
        check("t1_gap_old_period", t1 - t0, 24);
        check("t1_gap_new_period", t2 - t1, 8);

        // Reset during a trigger pulse
        wait_trig(1, 20, t0);
        reset = 1'b1;
        cycle();
        check("rst_mid_trigger", int'(bus.timer1_trigger), 0);
        check("rst_mid_busy",    int'(bus.timer1_busy),    0);
        check("rst_mid_address", int'(bus.timer1_address), 0);
        reset = 1'b0;
        bus.timer1_period = PW'(0);
        bus.timer1_start  = 1'b1;
        cycle();
        bus.timer1_start  = 1'b0;
        wait_trig(1, 20, t0);
        check("t1_post_rst_addr", int'(bus.timer1_address), 0);
        bus.timer1_stop = 1'b1;
        cycle();
        bus.timer1_stop = 1'b0;

        // Cascade: ch2 interval depends on whether the feature is built in
        bus.timer1_period  = PW'(1);
        bus.timer1_repeat  = 1'b1;
        bus.timer2_period  = PW'(2);
        bus.timer2_repeat  = 1'b1;
        bus.timer2_cascade = 1'b1;
        bus.timer1_start   = 1'b1;
        bus.timer2_start   = 1'b1;
        cycle();
        bus.timer1_start   = 1'b0;
        bus.timer2_start   = 1'b0;
        wait_trig(2, 100, t0);
        wait_trig(2, 100, t1);
        wait_trig(2, 100, t2);
        check("t2_casc_gap_a", t1 - t0, CASC_GAP);
        check("t2_casc_gap_b", t2 - t1, CASC_GAP);
        bus.timer1_stop    = 1'b1;
        bus.timer2_stop    = 1'b1;
        cycle();
        bus.timer1_stop    = 1'b0;
        bus.timer2_stop    = 1'b0;
        bus.timer2_cascade = 1'b0;

        // Randomized traffic, checked every cycle by the model
        for (int i = 0; i < 4000; i++) begin
            bus.timer1_start = ($urandom_range(0, 29) == 0);
            bus.timer1_stop  = ($urandom_range(0, 69) == 0);
            bus.timer2_start = ($urandom_range(0, 29) == 0);
            bus.timer2_stop  = ($urandom_range(0, 69) == 0);
            if ($urandom_range(0, 19) == 0) bus.timer1_period = PW'($urandom_range(0, 5));
            if ($urandom_range(0, 19) == 0) bus.timer2_period = PW'($urandom_range(0, 5));
            if ($urandom_range(0, 24) == 0) bus.timer1_repeat = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 24) == 0) bus.timer2_repeat = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) == 0) bus.timer2_cascade = ~bus.timer2_cascade;
            reset = ($urandom_range(0, 499) == 0);
            cycle();
        end
        bus.timer1_start = 1'b0;
        bus.timer1_stop  = 1'b0;
        bus.timer2_start = 1'b0;
        bus.timer2_stop  = 1'b0;
        reset = 1'b0;
        repeat (4) cycle();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
